// File: rtl/cpu_exec_ctrl_pkg.sv
// cpu_exec_ctrl_pkg: execution-state encoding and rate-switch decode, shared with the HEX/VGA status display
package cpu_exec_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;
   localparam int RATE_SEL_W = 6;
   // k = 1 for the highest set switch down to 6 for the lowest, 7 when all are off
   function automatic logic [2:0] rate_k(input logic [RATE_SEL_W-1:0] sel);
      return sel[5] ? 3'd1 : sel[4] ? 3'd2 : sel[3] ? 3'd3 :
             sel[2] ? 3'd4 : sel[1] ? 3'd5 : sel[0] ? 3'd6 : 3'd7;
   endfunction
endpackage

// File: rtl/cpu_exec_ctrl_key_debouncer.sv
// key_debouncer: 2-FF synchronizer, stability filter and one-clock press pulse for an active-low button
module key_debouncer #(
   parameter int DEB_CNT = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);
   localparam int DW = $clog2(DEB_CNT) + 1;
   logic [1:0] sync;
   logic level;
   logic [DW-1:0] cnt;
   logic flip;
   assign flip = (sync[1] != level) && (cnt == DW'(DEB_CNT - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], ~key_n};
         press <= flip & sync[1];
         level <= flip ? sync[1] : level;
         cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: single-clock CPU clock-enable sequencer with free-run, single-step,
// halt detection, CPU reset sequence and a saturating cycle counter
module cpu_exec_ctrl
   import cpu_exec_ctrl_pkg::*;
#(
   parameter int RATE_BASE  = 19,
   parameter int DEB_CNT    = 500000,
   parameter int RST_CYCLES = 16,
   parameter int CNT_W      = 32
) (
   input  logic             iCLK,
   input  logic             iRST_n,
   input  logic [5:0]       iRate_sel,
   input  logic             iMode_step,
   input  logic             iKey_step_n,
   input  logic             iKey_rst_n,
   input  logic             iHlt,
   output logic             oCpu_ce,
   output logic             oCpu_rst,
   output logic [CNT_W-1:0] oCycles,
   output logic [1:0]       oState,
   output logic             oTick_led
);
   localparam int PW = RATE_BASE + 7;
   localparam int RW = $clog2(RST_CYCLES) + 1;
   state_t st, st_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic [PW-1:0] pre, mask;
   logic [1:0] mode_sync;
   logic step_press, rst_press, tick, ce_n, rst_done;
   key_debouncer #(.DEB_CNT(DEB_CNT)) u_step_key (
      .clk(iCLK), .rst_n(iRST_n), .key_n(iKey_step_n), .press(step_press)
   );
   key_debouncer #(.DEB_CNT(DEB_CNT)) u_rst_key (
      .clk(iCLK), .rst_n(iRST_n), .key_n(iKey_rst_n), .press(rst_press)
   );
   // tick fires when the low RATE_BASE+k prescaler bits are all ones
   assign mask     = {PW{1'b1}} >> (3'd7 - rate_k(iRate_sel));
   assign tick     = &(pre | ~mask);
   assign rst_done = rcnt == RW'(RST_CYCLES - 1);
   assign oState   = st;
   always_comb begin
      st_n   = st;
      rcnt_n = rcnt;
      ce_n   = 1'b0;
      if (rst_press) begin
         st_n   = ST_RESET;
         rcnt_n = '0;
      end else begin
         case (st)
            ST_RESET: begin
               rcnt_n = rst_done ? '0 : rcnt + 1'b1;
               st_n   = !rst_done ? ST_RESET : mode_sync[1] ? ST_STEP : ST_RUN;
            end
            ST_RUN, ST_STEP: begin
               if (iHlt) st_n = ST_HALT;
               else if (mode_sync[1] != (st == ST_STEP)) st_n = mode_sync[1] ? ST_STEP : ST_RUN;
               else ce_n = (st == ST_RUN) ? tick : step_press;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         st        <= ST_RESET;
         rcnt      <= '0;
         pre       <= '0;
         mode_sync <= '0;
         oCpu_ce   <= 1'b0;
         oCpu_rst  <= 1'b1;
         oCycles   <= '0;
         oTick_led <= 1'b0;
      end else begin
         st        <= st_n;
         rcnt      <= rcnt_n;
         pre       <= pre + 1'b1;
         mode_sync <= {mode_sync[0], iMode_step};
         oCpu_ce   <= ce_n;
         oCpu_rst  <= st_n == ST_RESET;
         oCycles   <= (st_n == ST_RESET) ? '0 : (oCpu_ce && !(&oCycles)) ? oCycles + 1'b1 : oCycles;
         oTick_led <= oTick_led ^ ce_n;
      end
   end
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb_cpu_exec_ctrl: scenario tasks with randomized stimulus against a behavioural model of the sequencer
module tb_cpu_exec_ctrl;
   localparam int RSTC = 4;
   logic clk = 0, rst_n = 1, mode = 0, key_step_n = 1, key_rst_n = 1, hlt = 0;
   logic [5:0] sel = 6'b100000;
   logic ce, cpu_rst, led, ce2, rst2, led2;
   logic [1:0] state, st2;
   logic [3:0] cycles, cyc2;
   logic [8:0] act;
   int checks = 0, fails = 0;
   int m_pre, m_rc;
   logic [1:0] m_st;
   logic [3:0] m_cyc;
   logic m_ce, m_rst, m_led;
   logic raw_h[2][2];
   logic sh[2][4];
   logic acc[2], pr[2], mode_h[2];

   cpu_exec_ctrl #(.RATE_BASE(0), .DEB_CNT(4), .RST_CYCLES(RSTC), .CNT_W(4)) dut (
      .iCLK(clk), .iRST_n(rst_n), .iRate_sel(sel), .iMode_step(mode), .iKey_step_n(key_step_n),
      .iKey_rst_n(key_rst_n), .iHlt(hlt), .oCpu_ce(ce), .oCpu_rst(cpu_rst), .oCycles(cycles),
      .oState(state), .oTick_led(led)
   );
   cpu_exec_ctrl #(.RATE_BASE(0), .DEB_CNT(4), .RST_CYCLES(10), .CNT_W(4)) dut_long (
      .iCLK(clk), .iRST_n(rst_n), .iRate_sel(sel), .iMode_step(mode), .iKey_step_n(key_step_n),
      .iKey_rst_n(key_rst_n), .iHlt(hlt), .oCpu_ce(ce2), .oCpu_rst(rst2), .oCycles(cyc2),
      .oState(st2), .oTick_led(led2)
   );

   always #5 clk = ~clk;
   assign act = {ce, cpu_rst, state, cycles, led};

   function automatic logic [8:0] mv();
      return {m_ce, m_rst, m_st, m_cyc, m_led};
   endfunction

   function automatic void model_reset();
      m_pre = 0; m_rc = 0; m_st = 0; m_cyc = 0; m_ce = 0; m_rst = 1; m_led = 0;
      for (int i = 0; i < 2; i++) begin
         acc[i] = 0; pr[i] = 0; mode_h[i] = 0;
         for (int j = 0; j < 2; j++) raw_h[i][j] = 0;
         for (int j = 0; j < 4; j++) sh[i][j] = 0;
      end
   endfunction

   // one clock of the reference: keys seen two clocks late, accepted after 4 consecutive differing samples
   function automatic void model_edge();
      logic raw[2], npr[2];
      logic md, diff, tk, nce;
      logic [1:0] nst;
      int k;
      raw[0] = !key_step_n;
      raw[1] = !key_rst_n;
      for (int i = 0; i < 2; i++) begin
         for (int j = 3; j > 0; j--) sh[i][j] = sh[i][j-1];
         sh[i][0] = raw_h[i][1];
         diff = 1;
         for (int j = 0; j < 4; j++) if (sh[i][j] == acc[i]) diff = 0;
         npr[i] = diff && sh[i][0];
         if (diff) acc[i] = sh[i][0];
         raw_h[i][1] = raw_h[i][0];
         raw_h[i][0] = raw[i];
      end
      md = mode_h[1];
      mode_h[1] = mode_h[0];
      mode_h[0] = mode;
      k = 7;
      for (int b = 0; b < 6; b++) if (sel[b]) k = 6 - b;
      tk = (m_pre % (1 << k)) == (1 << k) - 1;
      nst = m_st;
      nce = 0;
      if (pr[1]) begin
         nst = 0; m_rc = 0;
      end else if (m_st == 0) begin
         if (m_rc == RSTC - 1) begin nst = md ? 2'd2 : 2'd1; m_rc = 0; end
         else m_rc++;
      end else if (m_st != 3) begin
         if (hlt) nst = 3;
         else if (md != (m_st == 2)) nst = md ? 2'd2 : 2'd1;
         else nce = (m_st == 1) ? tk : pr[0];
      end
      m_cyc = (nst == 0) ? 4'd0 : (m_ce && m_cyc != 4'hF) ? m_cyc + 4'd1 : m_cyc;
      m_led = m_led ^ nce;
      m_ce = nce;
      m_rst = nst == 0;
      m_st = nst;
      pr = npr;
      m_pre++;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic m, input logic [5:0] s);
      rst_n = 0;
      model_reset();
      mode = m; sel = s; key_step_n = 1; key_rst_n = 1; hlt = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      int n, last, gap;
      #1 rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (act !== 9'b0_1_00_0000_0) begin fails++; $display("FAIL reset_vals out=%b want=%b", act, 9'b0_1_00_0000_0); end
      @(negedge clk);
      mode = 0; sel = 6'b100000;
      rst_n = 1;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL reset_seq i=%0d out=%b model=%b", i, act, mv()); end
         checks++;
         if ({cpu_rst, ce} !== {i < 4 ? 1'b1 : 1'b0, (i >= 6 && i % 2 == 0) ? 1'b1 : 1'b0}) begin
            fails++; $display("FAIL reset_timing i=%0d rst=%b ce=%b", i, cpu_rst, ce);
         end
      end
      checks++;
      if (state !== 2'd1) begin fails++; $display("FAIL reset_to_run state=%0d want=1", state); end
      sel = 6'b000000;
      n = 0; last = 0; gap = 0;
      for (int i = 13; i <= 312; i++) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL slow_rate i=%0d out=%b model=%b", i, act, mv()); end
         if (ce) begin
            if (n > 0) gap = i - last;
            n++; last = i;
         end
      end
      checks++;
      if (n !== 2 || gap !== 128) begin fails++; $display("FAIL slow_period pulses=%0d gap=%0d want 2/128", n, gap); end
   endtask

   task automatic test_rates();
      logic [5:0] s;
      int n, per, k;
      for (int r = 0; r < 6; r++) begin
         s = (r == 0) ? 6'd0 : 6'($urandom);
         do_reset(0, s);
         k = 7;
         for (int b = 0; b < 6; b++) if (s[b]) k = 6 - b;
         per = 1 << k;
         n = 0;
         for (int i = 1; i <= 260; i++) begin
            cycle();
            if (ce) n++;
            checks++;
            if (act !== mv()) begin fails++; $display("FAIL rates sel=%b i=%0d out=%b model=%b", s, i, act, mv()); end
         end
         checks++;
         if (n !== 260 / per - 4 / per) begin fails++; $display("FAIL rate_count sel=%b got=%0d want=%0d", s, n, 260 / per - 4 / per); end
      end
   endtask

   task automatic test_single_step();
      logic lv[10];
      int du[10];
      int n;
      lv = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
      du = '{10, 2, 10, 10, 6, 8, 3, 10, 0, 0};
      do_reset(1, 6'b100000);
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL step_entry i=%0d out=%b model=%b", i, act, mv()); end
      end
      checks++;
      if ({state, cycles} !== 6'b10_0000) begin fails++; $display("FAIL step_idle state=%0d cyc=%0d want 2/0", state, cycles); end
      n = 0;
      for (int s = 0; s < 8; s++) begin
         key_step_n = !lv[s];
         for (int i = 0; i < du[s]; i++) begin
            cycle();
            if (ce) n++;
            checks++;
            if (act !== mv()) begin fails++; $display("FAIL step_seq s=%0d out=%b model=%b", s, act, mv()); end
         end
         if (s == 3 || s == 5 || s == 7) begin
            checks++;
            if (n !== (s == 3 ? 1 : 2) || cycles !== 4'(s == 3 ? 1 : 2)) begin
               fails++; $display("FAIL step_count s=%0d pulses=%0d cyc=%0d", s, n, cycles);
            end
         end
      end
      for (int s = 0; s < 40; s++) begin
         key_step_n = !key_step_n;
         repeat ($urandom_range(1, 8)) begin
            cycle();
            checks++;
            if (act !== mv()) begin fails++; $display("FAIL step_rand s=%0d out=%b model=%b", s, act, mv()); end
         end
      end
      key_step_n = 1;
   endtask

   task automatic test_halt();
      logic [3:0] frozen;
      do_reset(0, 6'b100000);
      for (int i = 0; i < 10 || (m_pre % 2) != 1; i++) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL halt_pre i=%0d out=%b model=%b", i, act, mv()); end
      end
      frozen = m_cyc;
      hlt = 1;
      cycle();
      hlt = 0;
      checks++;
      if ({ce, state} !== 3'b0_11) begin fails++; $display("FAIL halt_on_tick ce=%b state=%0d want 0/3", ce, state); end
      for (int i = 0; i < 30; i++) begin
         mode = (i >= 4 && i < 20);
         key_step_n = !(i >= 8 && i < 16);
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL halt_hold i=%0d out=%b model=%b", i, act, mv()); end
      end
      checks++;
      if ({state, cycles} !== {2'd3, frozen}) begin fails++; $display("FAIL halt_frozen state=%0d cyc=%0d want 3/%0d", state, cycles, frozen); end
   endtask

   task automatic test_manual_reset();
      int r;
      for (int m = 0; m < 2; m++) begin
         mode = m[0];
         key_rst_n = 0;
         r = 0;
         for (int i = 0; i < 30; i++) begin
            if (i == 8) key_rst_n = 1;
            cycle();
            if (cpu_rst) r++;
            checks++;
            if (act !== mv()) begin fails++; $display("FAIL man_rst m=%0d i=%0d out=%b model=%b", m, i, act, mv()); end
            checks++;
            if (cpu_rst && (cycles !== 4'd0 || ce !== 1'b0)) begin fails++; $display("FAIL man_rst_clear cyc=%0d ce=%b", cycles, ce); end
         end
         checks++;
         if (r !== 4 || state !== (m ? 2'd2 : 2'd1)) begin fails++; $display("FAIL man_rst_end m=%0d rst_clks=%0d state=%0d", m, r, state); end
      end
      rst_n = 0;
      model_reset();
      key_rst_n = 0; mode = 0; sel = 6'b100000; hlt = 0; key_step_n = 1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      r = 0;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (rst2) r++;
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL mid_rst_main i=%0d out=%b model=%b", i, act, mv()); end
         checks++;
         if (rst2 && {ce2, cyc2, led2} !== 6'b0) begin fails++; $display("FAIL mid_rst_quiet ce=%b cyc=%0d led=%b", ce2, cyc2, led2); end
      end
      checks++;
      if (r !== 16 || st2 !== 2'd1) begin fails++; $display("FAIL mid_rst_restart rst_clks=%0d state=%0d want 16/1", r, st2); end
      key_rst_n = 1;
   endtask

   task automatic test_saturation();
      do_reset(0, 6'b100000);
      for (int i = 0; i < 50; i++) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL sat_run i=%0d out=%b model=%b", i, act, mv()); end
      end
      checks++;
      if (cycles !== 4'hF) begin fails++; $display("FAIL sat_value cyc=%0d want 15", cycles); end
      #2 rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (act !== 9'b0_1_00_0000_0) begin fails++; $display("FAIL async_reset out=%b want=%b", act, 9'b0_1_00_0000_0); end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_mode_tick();
      int n;
      do_reset(0, 6'b100000);
      for (int i = 0; i < 10 || (m_pre % 2) != 1; i++) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL mode_pre i=%0d out=%b model=%b", i, act, mv()); end
      end
      mode = 1;
      repeat (3) begin
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL mode_switch out=%b model=%b", act, mv()); end
      end
      checks++;
      if ({ce, state} !== 3'b0_10) begin fails++; $display("FAIL mode_drop_tick ce=%b state=%0d want 0/2", ce, state); end
      n = 0;
      for (int i = 0; i < 16; i++) begin
         key_step_n = !(i < 6);
         cycle();
         if (ce) n++;
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL mode_step i=%0d out=%b model=%b", i, act, mv()); end
      end
      checks++;
      if (n !== 1) begin fails++; $display("FAIL mode_step_pulses got=%0d want=1", n); end
   endtask

   task automatic test_random();
      do_reset(1'($urandom), 6'($urandom));
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 30) == 0) sel = 6'($urandom);
         if ($urandom_range(0, 40) == 0) mode = !mode;
         if ($urandom_range(0, 5) == 0) key_step_n = !key_step_n;
         if ($urandom_range(0, 60) == 0) key_rst_n = !key_rst_n;
         hlt = $urandom_range(0, 150) == 0;
         cycle();
         checks++;
         if (act !== mv()) begin fails++; $display("FAIL random i=%0d out=%b model=%b", i, act, mv()); end
      end
   endtask

   initial begin
      test_reset();
      test_rates();
      test_single_step();
      test_halt();
      test_manual_reset();
      test_saturation();
      test_mode_tick();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
